// File: rtl/composition_stage_bw16_n3_pkg.sv
// Shared constants for the composition stage: state encoding, default width, child count.
package composition_stage_bw16_n3_pkg;

  localparam int unsigned DEFAULT_BW = 16;
  localparam int unsigned N_CHILD    = 3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_IN_ST    = 3'd1;
  localparam logic [2:0] S_IN_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT_ST   = 3'd3;
  localparam logic [2:0] S_OUT_WAIT = 3'd4;

endpackage

// File: rtl/composition_stage_bw16_n3_compose_ready_tracker.sv
// Accumulates which inner children have dropped RD since the shared start was raised.
module compose_ready_tracker
  import composition_stage_bw16_n3_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               clr,
  input  logic               en,
  input  logic [N_CHILD-1:0] crd,
  output logic               all_low_seen,
  output logic               all_high
);

  logic [N_CHILD-1:0] mask;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mask <= '0;
    end else if (clr) begin
      mask <= '0;
    end else if (en) begin
      mask <= mask | ~crd;
    end
  end

  // Include the current sample so the phase can close on the edge that sees the last drop.
  assign all_low_seen = &(mask | ~crd);
  assign all_high     = &crd;

endmodule

// File: rtl/composition_stage_bw16_n3.sv
// Composition node f(g0,g1,g2): runs three inner children, then the outer child on their results.
// Optional watchdog with ERR output is enabled by defining COMPOSE_TIMEOUT_EN.
module composition_stage_bw16_n3
  import composition_stage_bw16_n3_pkg::*;
#(
  parameter int unsigned BW = DEFAULT_BW
`ifdef COMPOSE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ST,
  output logic               RD,
  output logic [BW-1:0]      RES,
  output logic               CST,
  input  logic [N_CHILD-1:0] CRD,
  input  logic [BW-1:0]      CRES0,
  input  logic [BW-1:0]      CRES1,
  input  logic [BW-1:0]      CRES2,
  output logic               OST,
  input  logic               ORD,
  output logic [BW-1:0]      OIN0,
  output logic [BW-1:0]      OIN1,
  output logic [BW-1:0]      OIN2,
  input  logic [BW-1:0]      ORES
`ifdef COMPOSE_TIMEOUT_EN
  ,
  output logic               ERR
`endif
);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          st_hist;
  logic          start_c;
  logic          all_low_seen;
  logic          all_high;
  logic          clr_mask;
  logic          tmo_c;
  logic          rd_d;
  logic          cst_d;
  logic          ost_d;
  logic [BW-1:0] res_d;
  logic [BW-1:0] oin0_d;
  logic [BW-1:0] oin1_d;
  logic [BW-1:0] oin2_d;

  assign start_c = (state == S_IDLE) && ST && st_hist;

  compose_ready_tracker u_tracker (
    .CLK          (CLK),
    .RST          (RST),
    .clr          (clr_mask),
    .en           (state == S_IN_ST),
    .crd          (CRD),
    .all_low_seen (all_low_seen),
    .all_high     (all_high)
  );

`ifdef COMPOSE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             phase_done_c;
  logic             err_d;

  // A phase that completes on the expiry edge is allowed to proceed.
  assign phase_done_c = ((state == S_IN_WAIT) && all_high) || ((state == S_OUT_WAIT) && ORD);
  assign tmo_c = (state != S_IDLE) && (cnt == CNT_W'(TIMEOUT - 1)) && !phase_done_c;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= '0;
    end else if (((state_nxt == S_IN_ST) && (state != S_IN_ST)) ||
                 ((state_nxt == S_OUT_ST) && (state != S_OUT_ST))) begin
      cnt <= '0;
    end else if (state != S_IDLE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_c = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_IDLE;
      st_hist <= 1'b0;
      RD      <= 1'b1;
      RES     <= '0;
      CST     <= 1'b0;
      OST     <= 1'b0;
      OIN0    <= '0;
      OIN1    <= '0;
      OIN2    <= '0;
`ifdef COMPOSE_TIMEOUT_EN
      ERR     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      st_hist <= (state == S_IDLE) && ST;
      RD      <= rd_d;
      RES     <= res_d;
      CST     <= cst_d;
      OST     <= ost_d;
      OIN0    <= oin0_d;
      OIN1    <= oin1_d;
      OIN2    <= oin2_d;
`ifdef COMPOSE_TIMEOUT_EN
      ERR     <= err_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_c)      state_nxt = S_IN_ST;
      S_IN_ST:    if (all_low_seen) state_nxt = S_IN_WAIT;
      S_IN_WAIT:  if (all_high)     state_nxt = S_OUT_ST;
      S_OUT_ST:   if (!ORD)         state_nxt = S_OUT_WAIT;
      S_OUT_WAIT: if (ORD)          state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
    if (tmo_c) state_nxt = S_IDLE;
  end

  // Next values of the registered outputs
  always_comb begin
    rd_d     = RD;
    cst_d    = CST;
    ost_d    = OST;
    res_d    = RES;
    oin0_d   = OIN0;
    oin1_d   = OIN1;
    oin2_d   = OIN2;
    clr_mask = 1'b0;
`ifdef COMPOSE_TIMEOUT_EN
    err_d    = ERR;
`endif
    case (state)
      S_IDLE: begin
        if (start_c) begin
          rd_d  = 1'b0;
          cst_d = 1'b1;
`ifdef COMPOSE_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end
      end
      S_IN_ST: begin
        if (all_low_seen) cst_d = 1'b0;
      end
      S_IN_WAIT: begin
        if (all_high) begin
          oin0_d = CRES0;
          oin1_d = CRES1;
          oin2_d = CRES2;
          ost_d  = 1'b1;
        end
      end
      S_OUT_ST: begin
        if (!ORD) ost_d = 1'b0;
      end
      S_OUT_WAIT: begin
        if (ORD) begin
          res_d    = ORES;
          rd_d     = 1'b1;
          clr_mask = 1'b1;
        end
      end
      default: begin
        rd_d     = 1'b1;
        cst_d    = 1'b0;
        ost_d    = 1'b0;
        clr_mask = 1'b1;
      end
    endcase
    if (tmo_c) begin
      rd_d     = 1'b1;
      res_d    = '0;
      cst_d    = 1'b0;
      ost_d    = 1'b0;
      clr_mask = 1'b1;
`ifdef COMPOSE_TIMEOUT_EN
      err_d    = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_composition_stage_bw16_n3.sv
// Bench for composition_stage_bw16_n3: behavioural children, rule-level reference model, directed tests.
module tb_composition_stage_bw16_n3;

  localparam int unsigned BW = 16;
`ifdef COMPOSE_TIMEOUT_EN
  localparam int TMO  = 8;
  localparam int SKEW = 2;
`else
  localparam int SKEW = 4;
`endif

  logic          CLK, RST, ST, RD, CST, OST, ORD;
  logic [2:0]    CRD;
  logic [BW-1:0] RES, CRES0, CRES1, CRES2, OIN0, OIN1, OIN2, ORES;
`ifdef COMPOSE_TIMEOUT_EN
  logic          ERR;
`endif

  composition_stage_bw16_n3 #(
    .BW (BW)
`ifdef COMPOSE_TIMEOUT_EN
    , .TIMEOUT (TMO)
`endif
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .ST    (ST),
    .RD    (RD),
    .RES   (RES),
    .CST   (CST),
    .CRD   (CRD),
    .CRES0 (CRES0),
    .CRES1 (CRES1),
    .CRES2 (CRES2),
    .OST   (OST),
    .ORD   (ORD),
    .OIN0  (OIN0),
    .OIN1  (OIN1),
    .OIN2  (OIN2),
    .ORES  (ORES)
`ifdef COMPOSE_TIMEOUT_EN
    , .ERR (ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Child behaviour: start = two consecutive start samples, RD low for 2 cycles (inner child may be delayed).
  logic [BW-1:0] cval [3];
  int            skew [3];
  bit            c_hist [3];
  int            c_wait [3];
  int            c_low [3];
  bit            o_hist;
  int            o_low;
  logic [BW-1:0] o_val;
  bit            outer_never;
  logic          s_cst, s_ost;
  logic [BW-1:0] s_oin2;

  always @(posedge CLK) begin
    logic r;
    r = RST;
    #1;
    if (!r) begin
      CRD = 3'b111;
      ORD = 1'b1;
      for (int i = 0; i < 3; i++) begin
        c_hist[i] = 1'b0; c_wait[i] = 0; c_low[i] = 0;
      end
      o_hist = 1'b0; o_low = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (c_wait[i] > 0) begin
          c_wait[i]--;
          if (c_wait[i] == 0) begin CRD[i] = 1'b0; c_low[i] = 2; end
        end else if (c_low[i] > 0) begin
          c_low[i]--;
          if (c_low[i] == 0) begin
            CRD[i] = 1'b1;
            if (i == 0) CRES0 = cval[0];
            if (i == 1) CRES1 = cval[1];
            if (i == 2) CRES2 = cval[2];
          end
        end else if (c_hist[i] && s_cst) begin
          if (skew[i] == 0) begin CRD[i] = 1'b0; c_low[i] = 2; end
          else c_wait[i] = skew[i];
        end
        c_hist[i] = (c_wait[i] == 0 && c_low[i] == 0 && CRD[i] == 1'b1) ? s_cst : 1'b0;
      end
      if (o_low > 0) begin
        o_low--;
        if (o_low == 0) begin ORD = 1'b1; ORES = o_val; end
      end else if (o_hist && s_ost && !outer_never) begin
        ORD = 1'b0; o_low = 2; o_val = s_oin2;
      end
      o_hist = (o_low == 0) ? s_ost : 1'b0;
    end
  end

  // Reference model: transaction phases advanced from the input values seen at each rising edge.
  bit            m_valid = 1'b0;
  int            m_phase;
  int            m_cnt;
  bit            m_st_prev;
  logic [2:0]    m_seen;
  logic          m_rd, m_cst, m_ost, m_err;
  logic [BW-1:0] m_res;
  logic [BW-1:0] m_oin [3];

  always @(posedge CLK) begin
    int ph0;
    bit tmo, done;
    if (!RST) begin
      m_valid = 1'b1; m_phase = 0; m_cnt = 0; m_st_prev = 1'b0; m_seen = '0;
      m_rd = 1'b1; m_cst = 1'b0; m_ost = 1'b0; m_err = 1'b0; m_res = '0;
      for (int i = 0; i < 3; i++) m_oin[i] = '0;
    end else begin
      ph0 = m_phase;
      tmo = 1'b0;
`ifdef COMPOSE_TIMEOUT_EN
      tmo = (ph0 != 0) && (m_cnt == TMO - 1);
`endif
      case (ph0)
        0: if (ST && m_st_prev) begin
             m_rd = 1'b0; m_cst = 1'b1; m_err = 1'b0; m_seen = '0; m_phase = 1;
           end
        1: begin
             m_seen = m_seen | ~CRD;
             if (m_seen == 3'b111) begin m_cst = 1'b0; m_phase = 2; end
           end
        2: if (CRD == 3'b111) begin
             m_oin[0] = CRES0; m_oin[1] = CRES1; m_oin[2] = CRES2;
             m_ost = 1'b1; m_phase = 3;
           end
        3: if (!ORD) begin m_ost = 1'b0; m_phase = 4; end
        4: if (ORD) begin m_res = ORES; m_rd = 1'b1; m_phase = 0; end
        default: m_phase = 0;
      endcase
      done = (ph0 == 2 && m_phase == 3) || (ph0 == 4 && m_phase == 0);
      if (tmo && !done) begin
        m_err = 1'b1; m_res = '0; m_rd = 1'b1; m_cst = 1'b0; m_ost = 1'b0; m_phase = 0;
      end
      if ((m_phase == 1 && ph0 != 1) || (m_phase == 3 && ph0 != 3)) m_cnt = 0;
      else if (ph0 != 0) m_cnt++;
      m_st_prev = (ph0 == 0) && (ST == 1'b1);
    end
  end

  // Compare every cycle on the falling edge; also measure pulse lengths.
  int rd_low_cnt = 0, last_rd_low = 0;
  int cst_cnt = 0, last_cst_len = 0;
  int ost_cnt = 0, last_ost_len = 0;

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("rd", 32'(RD), 32'(m_rd));
      chk("res", 32'(RES), 32'(m_res));
      chk("cst", 32'(CST), 32'(m_cst));
      chk("ost", 32'(OST), 32'(m_ost));
      chk("oin0", 32'(OIN0), 32'(m_oin[0]));
      chk("oin1", 32'(OIN1), 32'(m_oin[1]));
      chk("oin2", 32'(OIN2), 32'(m_oin[2]));
`ifdef COMPOSE_TIMEOUT_EN
      chk("err", 32'(ERR), 32'(m_err));
`endif
      if (RD === 1'b0) rd_low_cnt++;
      else if (rd_low_cnt > 0) begin last_rd_low = rd_low_cnt; rd_low_cnt = 0; end
      if (CST === 1'b1) cst_cnt++;
      else if (cst_cnt > 0) begin last_cst_len = cst_cnt; cst_cnt = 0; end
      if (OST === 1'b1) ost_cnt++;
      else if (ost_cnt > 0) begin last_ost_len = ost_cnt; ost_cnt = 0; end
    end
    s_cst  = CST;
    s_ost  = OST;
    s_oin2 = OIN2;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic start_pulse(input int n);
    @(posedge CLK); #1;
    ST = 1'b1;
    step(n);
    ST = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge CLK);
      if (RD === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s: RD still low after 60 cycles", name);
    end
  endtask

  task automatic wait_ost_fall(input string name);
    bit seen = 1'b0, ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (OST === 1'b1) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s: OST never completed a pulse", name);
    end
  endtask

  task automatic set_children(input logic [BW-1:0] v0, input logic [BW-1:0] v1, input logic [BW-1:0] v2);
    cval[0] = v0; cval[1] = v1; cval[2] = v2;
  endtask

  initial begin
    RST = 1'b0; ST = 1'b0; CRD = 3'b111; ORD = 1'b1;
    CRES0 = '0; CRES1 = '0; CRES2 = '0; ORES = '0;
    outer_never = 1'b0;
    for (int i = 0; i < 3; i++) skew[i] = 0;
    set_children(16'h0001, 16'h0002, 16'h0003);

    // Reset held for 3 cycles
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_rd", 32'(RD), 32'd1);
    chk("reset_res", 32'(RES), 32'd0);
    chk("reset_cst", 32'(CST), 32'd0);
    chk("reset_ost", 32'(OST), 32'd0);
    chk("reset_oin", {OIN0, OIN1}, 32'd0);
    #1 RST = 1'b1;
    step(2);

    // Nominal run
    start_pulse(2);
    wait_idle("nominal");
    step(1);
    chk("nominal_res", 32'(RES), 32'h0003);
    chk("nominal_oin0", 32'(OIN0), 32'h0001);
    chk("nominal_oin1", 32'(OIN1), 32'h0002);
    chk("nominal_oin2", 32'(OIN2), 32'h0003);
    chk("nominal_rd_low", 32'(last_rd_low), 32'd10);
    chk("nominal_cst_len", 32'(last_cst_len), 32'd3);
    step(2);

    // Single-cycle pulse and a 1-0-1 pattern must not start
    start_pulse(1);
    step(1);
    ST = 1'b1; step(1); ST = 1'b0;
    step(6);
    chk("pulse_rd", 32'(RD), 32'd1);
    chk("pulse_cst", 32'(CST), 32'd0);

    // Child 2 drops late
    skew[2] = SKEW;
    start_pulse(2);
    wait_idle("skew");
    step(1);
    chk("skew_res", 32'(RES), 32'h0003);
    chk("skew_cst_len", 32'(last_cst_len), 32'(3 + SKEW));
    chk("skew_rd_low", 32'(last_rd_low), 32'(10 + SKEW));
    skew[2] = 0;
    step(2);

    // Different data pattern
    set_children(16'hA5A5, 16'h1234, 16'hFFFF);
    start_pulse(2);
    wait_idle("pattern");
    step(1);
    chk("pattern_res", 32'(RES), 32'hFFFF);
    chk("pattern_oin0", 32'(OIN0), 32'hA5A5);
    chk("pattern_oin1", 32'(OIN1), 32'h1234);
    chk("pattern_rd_low", 32'(last_rd_low), 32'd10);
    step(2);

    // Reset while waiting on the outer child, then a clean run
    set_children(16'h0001, 16'h0002, 16'h0003);
    start_pulse(2);
    wait_ost_fall("midreset");
    #1 RST = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    chk("midreset_rd", 32'(RD), 32'd1);
    chk("midreset_res", 32'(RES), 32'd0);
    chk("midreset_ost", 32'(OST), 32'd0);
    chk("midreset_oin2", 32'(OIN2), 32'd0);
    step(4);
    start_pulse(2);
    wait_idle("after_reset");
    step(1);
    chk("after_reset_res", 32'(RES), 32'h0003);
    chk("after_reset_rd_low", 32'(last_rd_low), 32'd10);
    step(2);

`ifdef COMPOSE_TIMEOUT_EN
    // Outer child never responds
    outer_never = 1'b1;
    start_pulse(2);
    wait_idle("timeout");
    step(1);
    chk("timeout_err", 32'(ERR), 32'd1);
    chk("timeout_rd", 32'(RD), 32'd1);
    chk("timeout_res", 32'(RES), 32'd0);
    chk("timeout_ost_len", 32'(last_ost_len), 32'(TMO));
    outer_never = 1'b0;
    step(2);
    start_pulse(2);
    chk("timeout_err_clear", 32'(ERR), 32'd0);
    wait_idle("timeout_recover");
    step(1);
    chk("timeout_recover_res", 32'(RES), 32'h0003);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/composition_stage_bw16_n3.md
# composition_stage_bw16_n3

Sequencing stage for one Maltsev composition node: f(g0, g1, g2). It sits directly upstream of the operation blocks (projections, increments, and so on). It starts three inner operation blocks together, waits for all three to complete, and latches their results. It then starts the outer operation on those results and returns the outer result to its own parent. Every interface uses the same ST/RD handshake the operation blocks use, so composition nodes nest without glue logic.

## Interface
Parameters:
- BW, 16, data width of every result bus
- TIMEOUT, 255, watchdog limit in cycles per child phase (used only with COMPOSE_TIMEOUT_EN)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous reset, active-low
- ST  in  1  start request from parent
- RD  out  1  ready to parent; 0 while a computation is in flight
- RES  out  BW  result to parent
- CST  out  1  start to the three inner children (shared)
- CRD  in  3  ready from inner children, bit i = child i
- CRES0, CRES1, CRES2  in  BW each  inner child results
- OST  out  1  start to the outer child
- ORD  in  1  ready from the outer child
- OIN0, OIN1, OIN2  out  BW each  latched inner results, wired to the outer child's IN0..IN2
- ORES  in  BW  outer child result
- ERR  out  1  timeout flag (present only with COMPOSE_TIMEOUT_EN)

## Operation
- Start rule (parent side, identical to the children): a start is ST sampled 1 on two consecutive edges while in IDLE. ST is ignored in all other states.
- FSM states: IDLE, IN_ST, IN_WAIT, OUT_ST, OUT_WAIT.
- IDLE: RD=1, CST=0, OST=0. On a start, set RD=0 and CST=1, then go to IN_ST.
- IN_ST: hold CST=1. A 3-bit seen-low mask sets bit i when CRD[i]==0. When the mask is 111, set CST=0 and go to IN_WAIT.
- IN_WAIT: when CRD==111, capture CRES0..2 into OIN0..2, set OST=1 and go to OUT_ST.
- OUT_ST: hold OST=1 until ORD is sampled 0, then set OST=0 and go to OUT_WAIT.
- OUT_WAIT: when ORD is sampled 1, set RES=ORES and RD=1, clear the mask, and go to IDLE.
- Results pass through unmodified; no arithmetic is done in this stage.
- Reset (RST==0), including mid-operation: state=IDLE, RD=1, RES=0, CST=0, OST=0, OIN0..2=0, mask=0, ERR=0, ST history=0. An in-flight computation is discarded.
- Children whose RD drops at different cycles are tolerated, because the mask accumulates. A child that drops and recovers before its siblings drop stays marked.

## Timing
- RD falls on the edge that samples the second consecutive ST=1. CST rises on the same edge.
- With minimal-latency children (RD low 2 cycles, falling on the edge after the second ST sample), RD is low for exactly 10 cycles.
- RES and RD=1 update on the same edge, so the parent may sample RES whenever RD=1.
- OIN0..2 stay stable from capture until the next capture; the outer child may read them at any time.
- CST and OST are each held high for at least 2 edges, which satisfies the children's start rule.

## Configuration
- COMPOSE_TIMEOUT_EN:
  - Defined: a cycle counter clears on entry to IN_ST and on entry to OUT_ST. If the counter reaches TIMEOUT before that phase completes, the stage sets ERR=1, RES=0 and RD=1, drops CST and OST, and returns to IDLE. ERR clears on the next accepted start.
  - Undefined: there is no counter and no ERR port, and the stage waits indefinitely.

## Structure
- Shared package holds the FSM state encoding (3-bit localparams), the default BW, and the child count constant (3).
- One natural sub-module: compose_ready_tracker. It holds the seen-low mask and produces all_low_seen and all_high from CRD.

## Test plan
- Reset: hold RST=0 for 3 cycles -> RD=1, RES=0, CST=0, OST=0, OIN*=0.
- Nominal: children are projection-style models returning 0x0001, 0x0002 and 0x0003, and the outer child returns IN2 -> OIN=1,2,3, RES=0x0003, RD low exactly 10 cycles.
- Single-cycle ST pulse -> no start: RD stays 1 and CST stays 0.
- Skewed children: child 2's RD falls 4 cycles after the others -> CST held until child 2 drops, and RES is still correct.
- Reset asserted in OUT_WAIT -> next edge RD=1, RES=0, OST=0. A new start then completes normally.
- With COMPOSE_TIMEOUT_EN and TIMEOUT=8, the outer child never drops ORD -> ERR=1, RD=1 and RES=0, 8 cycles after entering OUT_ST.
